z80_sram_arbiter: RTL and testbench



---
 rtl/z80_sram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_z80_sram_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_sram_arbiter.sv
// Shares one external SRAM between the Z80 CPU bus and the video fetch engine.
// Optional build macro VIDEO_PRIORITY_EN: video wins every tie instead of round-robin.
module z80_sram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int SRAM_WAIT = 2
) (
  input  logic              CLK50MHZ,
  input  logic              RESET,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DOUT,
  output logic [DATA_W-1:0] CPU_DIN,
  output logic              CPU_ACK,
  output logic              CPU_WAIT_N,
  input  logic              VID_REQ,
  input  logic [ADDR_W-1:0] VID_ADDR,
  output logic [DATA_W-1:0] VID_DIN,
  output logic              VID_ACK,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_O,
  output logic              SRAM_DQ_OE,
  input  logic [DATA_W-1:0] SRAM_DQ_I,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_VID = 1'b1;

  localparam logic [3:0] WAIT_LOAD = 4'(SRAM_WAIT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_din_q, cpu_din_d;
  logic [DATA_W-1:0] vid_din_q, vid_din_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vid_ack_q, vid_ack_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              grant_vid;

  // Tie-break between simultaneous requests.
  always_comb begin
    if (CPU_REQ && VID_REQ) begin
`ifdef VIDEO_PRIORITY_EN
      grant_vid = 1'b1;
`else
      grant_vid = (last_grant_q == OWN_CPU);
`endif
    end else begin
      grant_vid = VID_REQ;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_din_d    = cpu_din_q;
    vid_din_d    = vid_din_q;
    cpu_ack_d    = 1'b0;
    vid_ack_d    = 1'b0;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    dq_oe_d      = dq_oe_q;

    case (state_q)
      ST_IDLE: begin
        if (CPU_REQ || VID_REQ) begin
          owner_d      = grant_vid ? OWN_VID : OWN_CPU;
          last_grant_d = owner_d;
          // Video is read-only, so a video grant never drives write strobes.
          we_d         = !grant_vid && CPU_WE;
          addr_d       = grant_vid ? VID_ADDR : CPU_ADDR;
          if (!grant_vid) wdata_d = CPU_DOUT;
          cnt_d        = WAIT_LOAD;
          ce_n_d       = 1'b0;
          oe_n_d       = we_d;
          we_n_d       = !we_d;
          dq_oe_d      = we_d;
          state_d      = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q == OWN_VID) vid_din_d = SRAM_DQ_I;
            else                    cpu_din_d = SRAM_DQ_I;
          end
          cpu_ack_d = (owner_q == OWN_CPU);
          vid_ack_d = (owner_q == OWN_VID);
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          dq_oe_d   = 1'b0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Reset deasserts the strobes asynchronously and drops any access in flight.
  always_ff @(posedge CLK50MHZ or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_VID;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_din_q    <= '0;
      vid_din_q    <= '0;
      cpu_ack_q    <= 1'b0;
      vid_ack_q    <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_din_q    <= cpu_din_d;
      vid_din_q    <= vid_din_d;
      cpu_ack_q    <= cpu_ack_d;
      vid_ack_q    <= vid_ack_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      dq_oe_q      <= dq_oe_d;
    end
  end

  assign CPU_DIN    = cpu_din_q;
  assign CPU_ACK    = cpu_ack_q;
  assign CPU_WAIT_N = !(CPU_REQ && !cpu_ack_q);
  assign VID_DIN    = vid_din_q;
  assign VID_ACK    = vid_ack_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_DQ_O  = wdata_q;
  assign SRAM_DQ_OE = dq_oe_q;
  assign SRAM_CE_N  = ce_n_q;
  assign SRAM_OE_N  = oe_n_q;
  assign SRAM_WE_N  = we_n_q;

endmodule

// File: tb/tb_z80_sram_arbiter.sv
// Self-checking bench for z80_sram_arbiter: directed scenarios plus random traffic
// against a transaction-timeline model of the arbiter and a reference memory.
module tb_z80_sram_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CPU_REQ = 1'b0, CPU_WE = 1'b0;
  logic [15:0] CPU_ADDR = '0;
  logic [7:0]  CPU_DOUT = '0;
  logic [7:0]  CPU_DIN;
  logic        CPU_ACK, CPU_WAIT_N;
  logic        VID_REQ = 1'b0;
  logic [15:0] VID_ADDR = '0;
  logic [7:0]  VID_DIN;
  logic        VID_ACK;
  logic [15:0] SRAM_ADDR;
  logic [7:0]  SRAM_DQ_O, SRAM_DQ_I;
  logic        SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

  always #5 clk = ~clk;

  z80_sram_arbiter #(.ADDR_W(16), .DATA_W(8), .SRAM_WAIT(W)) dut (
    .CLK50MHZ(clk), .RESET(rst),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DOUT(CPU_DOUT),
    .CPU_DIN(CPU_DIN), .CPU_ACK(CPU_ACK), .CPU_WAIT_N(CPU_WAIT_N),
    .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_DIN(VID_DIN), .VID_ACK(VID_ACK),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_DQ_I(SRAM_DQ_I), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N)
  );

  // External SRAM: asynchronous read, write captured on clock edges while strobed.
  logic [7:0] sram_mem [0:65535];
  logic [7:0] ref_mem  [0:65535];
  assign SRAM_DQ_I = sram_mem[SRAM_ADDR];
  always @(posedge clk)
    if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_OE) sram_mem[SRAM_ADDR] <= SRAM_DQ_O;

  typedef struct { bit we; logic [15:0] addr; logic [7:0] data; } req_t;
  req_t        cpu_q[$];
  logic [15:0] vid_q[$];

  int vectors = 0, miscompares = 0, cyc = 0;
  bit rnd_en = 0;

  // Model: one access at a time, timeline expressed relative to the grant cycle.
  bit          m_act, m_own, m_we, m_last;
  int          m_s;
  logic [15:0] m_addr, m_sram_addr;
  logic [7:0]  m_data, m_cpu_din, m_vid_din;
  bit          grant_log[$];
  int          cpu_grant_cyc, vid_grant_cyc, cpu_ack_cyc, vid_ack_cyc;
  int          oe_low_cnt, we_low_cnt;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_last = 1'b1; m_sram_addr = '0; m_cpu_din = '0; m_vid_din = '0;
    cpu_ack_cyc = -1; vid_ack_cyc = -1;
    grant_log.delete();
  endtask

  task automatic step();
    bit idle, acc, done, drop_c, drop_v, own;
    @(negedge clk);
    cyc++;
    idle = !m_act;
    acc  = m_act && (cyc >= m_s + 1) && (cyc <= m_s + W);
    done = m_act && (cyc == m_s + W + 1);
    if (SRAM_OE_N === 1'b0) oe_low_cnt++;
    if (SRAM_WE_N === 1'b0) we_low_cnt++;
    check("ce_n",  32'(SRAM_CE_N),  32'(!acc));
    check("oe_n",  32'(SRAM_OE_N),  32'(!(acc && !m_we)));
    check("we_n",  32'(SRAM_WE_N),  32'(!(acc && m_we)));
    check("dq_oe", 32'(SRAM_DQ_OE), 32'(acc && m_we));
    if (acc && m_we) check("dq_o", 32'(SRAM_DQ_O), 32'(m_data));
    check("sram_addr", 32'(SRAM_ADDR), 32'(m_sram_addr));
    check("cpu_ack", 32'(CPU_ACK), 32'(done && !m_own));
    check("vid_ack", 32'(VID_ACK), 32'(done && m_own));
    if (done) begin
      if (m_we) ref_mem[m_addr] = m_data;
      else if (m_own) m_vid_din = ref_mem[m_addr];
      else m_cpu_din = ref_mem[m_addr];
      if (m_own) vid_ack_cyc = cyc; else cpu_ack_cyc = cyc;
      m_act = 0;
    end
    check("cpu_din", 32'(CPU_DIN), 32'(m_cpu_din));
    check("vid_din", 32'(VID_DIN), 32'(m_vid_din));
    check("cpu_wait_n", 32'(CPU_WAIT_N), 32'(!(CPU_REQ && !(done && !m_own))));

    // Requesters release on the edge that ends their ACK cycle.
    drop_c = done && !m_own;
    drop_v = done && m_own;
    if (drop_c) begin
      CPU_REQ = 0; CPU_WE = 1'($urandom); CPU_ADDR = 16'($urandom); CPU_DOUT = 8'($urandom);
    end
    if (drop_v) begin
      VID_REQ = 0; VID_ADDR = 16'($urandom);
    end
    if (!CPU_REQ && !drop_c && cpu_q.size() > 0 && (!rnd_en || $urandom_range(0, 1) == 1)) begin
      CPU_REQ = 1; CPU_WE = cpu_q[0].we; CPU_ADDR = cpu_q[0].addr; CPU_DOUT = cpu_q[0].data;
      void'(cpu_q.pop_front());
    end
    if (!VID_REQ && !drop_v && vid_q.size() > 0 && (!rnd_en || $urandom_range(0, 1) == 1)) begin
      VID_REQ = 1; VID_ADDR = vid_q.pop_front();
    end

    if (idle && (CPU_REQ || VID_REQ)) begin
      if (CPU_REQ && VID_REQ) begin
`ifdef VIDEO_PRIORITY_EN
        own = 1'b1;
`else
        own = !m_last;
`endif
      end else begin
        own = VID_REQ;
      end
      m_act = 1; m_s = cyc; m_own = own; m_last = own;
      m_we   = own ? 1'b0 : CPU_WE;
      m_addr = own ? VID_ADDR : CPU_ADDR;
      m_data = CPU_DOUT;
      m_sram_addr = m_addr;
      grant_log.push_back(own);
      if (own) vid_grant_cyc = cyc; else cpu_grant_cyc = cyc;
    end
  endtask

  task automatic do_reset();
    rst = 1; CPU_REQ = 0; VID_REQ = 0;
    cpu_q.delete(); vid_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_cpu_ack(string name);
    bit seen = 0;
    cpu_ack_cyc = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = (cpu_ack_cyc >= 0);
    end
    check({name, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_vid_ack(string name);
    bit seen = 0;
    vid_ack_cyc = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = (vid_ack_cyc >= 0);
    end
    check({name, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      sram_mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
      ref_mem[a]  = sram_mem[a];
    end
    sram_mem[16'h1234] = 8'hA5;
    ref_mem[16'h1234]  = 8'hA5;
    model_reset();

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ce_n",   32'(SRAM_CE_N),  32'd1);
    check("rst_oe_n",   32'(SRAM_OE_N),  32'd1);
    check("rst_we_n",   32'(SRAM_WE_N),  32'd1);
    check("rst_dq_oe",  32'(SRAM_DQ_OE), 32'd0);
    check("rst_dq_o",   32'(SRAM_DQ_O),  32'd0);
    check("rst_addr",   32'(SRAM_ADDR),  32'd0);
    check("rst_acks",   32'({CPU_ACK, VID_ACK}), 32'd0);
    check("rst_dins",   32'({CPU_DIN, VID_DIN}), 32'd0);
    check("rst_wait_n", 32'(CPU_WAIT_N), 32'd1);
    do_reset();

    // CPU read of 0x1234.
    oe_low_cnt = 0;
    cpu_q.push_back('{1'b0, 16'h1234, 8'h00});
    wait_cpu_ack("rd1234");
    check("rd1234_latency", 32'(cpu_ack_cyc - cpu_grant_cyc), 32'd3);
    check("rd1234_data",    32'(CPU_DIN), 32'hA5);
    check("rd1234_oe_cycles", 32'(oe_low_cnt), 32'd2);

    // CPU write of 0x5A to 0x0010, then read it back.
    we_low_cnt = 0; oe_low_cnt = 0;
    cpu_q.push_back('{1'b1, 16'h0010, 8'h5A});
    wait_cpu_ack("wr0010");
    check("wr0010_we_cycles", 32'(we_low_cnt), 32'd2);
    check("wr0010_oe_cycles", 32'(oe_low_cnt), 32'd0);
    check("wr0010_din_kept",  32'(CPU_DIN), 32'hA5);
    cpu_q.push_back('{1'b0, 16'h0010, 8'h00});
    wait_cpu_ack("rd0010");
    check("rd0010_data", 32'(CPU_DIN), 32'h5A);

    // Simultaneous requests held continuously.
    do_reset();
    repeat (2) cpu_q.push_back('{1'b0, 16'h0003, 8'h00});
    vid_q.push_back(16'h0007); vid_q.push_back(16'h0008);
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) step();
    check("tie_grants", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() >= 4) begin
`ifdef VIDEO_PRIORITY_EN
      check("tie_order", 32'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}), 32'b1100);
`else
      check("tie_order", 32'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}), 32'b0101);
`endif
    end
    for (int i = 0; i < 10; i++) step();

    // Video request arriving while a CPU access is in progress.
    do_reset();
    cpu_ack_cyc = -1;
    cpu_q.push_back('{1'b0, 16'h0004, 8'h00});
    step();
    step();
    vid_q.push_back(16'h0009);
    wait_vid_ack("vid_late");
    check("vid_late_grant", 32'(vid_grant_cyc - cpu_ack_cyc), 32'd1);
    check("vid_late_latency", 32'(vid_ack_cyc - vid_grant_cyc), 32'd3);
    check("vid_late_data", 32'(VID_DIN), 32'(8'h09 ^ 8'h3C));

    // Reset in the middle of a write access.
    do_reset();
    cpu_q.push_back('{1'b1, 16'hFFFF, 8'h77});
    step();
    step();
    check("mid_we_low", 32'(SRAM_WE_N), 32'd0);
    #1 rst = 1;
    #1;
    check("mid_rst_ce_n",  32'(SRAM_CE_N),  32'd1);
    check("mid_rst_we_n",  32'(SRAM_WE_N),  32'd1);
    check("mid_rst_dq_oe", 32'(SRAM_DQ_OE), 32'd0);
    do_reset();
    for (int i = 0; i < 8; i++) step();

    // Random traffic on a small address window so reads observe earlier writes.
    rnd_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if (cpu_q.size() == 0 && $urandom_range(0, 2) == 0)
        cpu_q.push_back('{1'($urandom), {12'h000, 4'($urandom)}, 8'($urandom)});
      if (vid_q.size() == 0 && $urandom_range(0, 2) == 0)
        vid_q.push_back({12'h000, 4'($urandom)});
      step();
    end
    rnd_en = 0;
    for (int i = 0; i < 40; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
